// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port synchronous instruction memory between the fetch port and the
// debug/loader port, and routes the one-cycle-latency read data back to whichever port issued the read.
module imem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DBG_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req_i,
    input  logic [AW-1:0] f_addr_i,
    output logic          f_gnt_o,
    output logic [DW-1:0] f_rdata_o,
    output logic          f_rvalid_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_rvalid_o,
    output logic          mem_ce_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          fetch_stall_o
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DEBUG
    } owner_e;

    localparam logic [3:0] BURST_MAX = 4'(DBG_BURST);

    owner_e     owner_q, owner_d;
    logic [3:0] burst_q, burst_d;
    logic       f_rvalid_q, d_rvalid_q;
    logic       f_gnt, d_gnt;

    // Debug wins contention until it has used up its burst allowance.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (f_req_i && d_req_i) begin
                if (burst_q == BURST_MAX) begin
                    f_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                f_gnt = f_req_i;
                d_gnt = d_req_i;
            end
        end
    end

    always_comb begin
        mem_ce_o    = f_gnt | d_gnt;
        mem_we_o    = d_gnt & d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (f_gnt) begin
            mem_addr_o = f_addr_i;
        end else if (d_gnt) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
        f_gnt_o       = f_gnt;
        d_gnt_o       = d_gnt;
        fetch_stall_o = rst & f_req_i & ~f_gnt;
    end

    always_comb begin
        burst_d = burst_q;
        if (f_gnt || !f_req_i) begin
            burst_d = 4'd0;
        end else if (d_gnt && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + 4'd1;
        end

        owner_d = OWN_NONE;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt && !d_we_i) begin
            owner_d = OWN_DEBUG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            burst_q    <= 4'd0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            f_rvalid_q <= (owner_d == OWN_FETCH);
            d_rvalid_q <= (owner_d == OWN_DEBUG);
        end
    end

    // Memory data arrives in the owner cycle; steer it, zero elsewhere.
    always_comb begin
        f_rvalid_o = f_rvalid_q;
        d_rvalid_o = d_rvalid_q;
        f_rdata_o  = f_rvalid_q ? mem_rdata_i : '0;
        d_rdata_o  = d_rvalid_q ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: a synchronous memory model, a driver checking grants,
// and a monitor matching read responses against queued expectations.
module tb_imem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          f_req_i = 1'b0;
    logic [AW-1:0] f_addr_i = '0;
    logic          f_gnt_o;
    logic [DW-1:0] f_rdata_o;
    logic          f_rvalid_o;
    logic          d_req_i = 1'b0;
    logic          d_we_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0;
    logic          d_gnt_o;
    logic [DW-1:0] d_rdata_o;
    logic          d_rvalid_o;
    logic          mem_ce_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          fetch_stall_o;

    imem_port_arbiter #(.AW(AW), .DW(DW), .DBG_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rdata_o(f_rdata_o), .f_rvalid_o(f_rvalid_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .fetch_stall_o(fetch_stall_o)
    );

    always #5 clk = ~clk;

    // Memory model: word i initialised to 0x1000_0000 + i.
    logic [DW-1:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
            else          mem_rdata_i <= mem[mem_addr_o[9:2]];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;
    exp_t fq[$];
    exp_t dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Vector: requests plus hand-computed grant and read data.
    typedef struct {
        string       tag;
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        efg;
        logic        edg;
        logic [31:0] erd;
    } vec_t;

    task automatic apply(input vec_t v, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        f_req_i = v.fr; f_addr_i = v.fa;
        d_req_i = v.dr; d_we_i = v.dw; d_addr_i = v.da; d_wdata_i = v.dd;
        #2;
        chk({v.tag, "_f_gnt"}, 32'(f_gnt_o), 32'(v.efg));
        chk({v.tag, "_d_gnt"}, 32'(d_gnt_o), 32'(v.edg));
        chk({v.tag, "_stall"}, 32'(fetch_stall_o), 32'(v.fr & ~v.efg));
        chk({v.tag, "_mem_ce"}, 32'(mem_ce_o), 32'(v.efg | v.edg));
        chk({v.tag, "_mem_we"}, 32'(mem_we_o), 32'(v.edg & v.dw));
        chk({v.tag, "_mem_addr"}, mem_addr_o, v.efg ? v.fa : (v.edg ? v.da : 32'h0));
        if (push) begin
            e.due = cyc + 1;
            e.data = v.erd;
            if (v.efg) fq.push_back(e);
            else if (v.edg && !v.dw) dq.push_back(e);
        end
    endtask

    // Monitor: pops expectations as responses appear; flags missing, extra or misrouted data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (f_rvalid_o && d_rvalid_o) chk("both_rvalid", 32'd1, 32'd0);
            if (f_rvalid_o) begin
                if (fq.size() == 0) chk("f_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    chk("f_rdata", f_rdata_o, fq[0].data);
                    chk("f_latency", 32'(cyc), 32'(fq[0].due));
                    void'(fq.pop_front());
                end
            end else begin
                chk("f_rdata_idle", f_rdata_o, 32'h0);
                if (fq.size() > 0 && fq[0].due <= cyc) begin
                    chk("f_missing_rvalid", 32'd0, 32'd1);
                    void'(fq.pop_front());
                end
            end
            if (d_rvalid_o) begin
                if (dq.size() == 0) chk("d_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    chk("d_rdata", d_rdata_o, dq[0].data);
                    chk("d_latency", 32'(cyc), 32'(dq[0].due));
                    void'(dq.pop_front());
                end
            end else begin
                chk("d_rdata_idle", d_rdata_o, 32'h0);
                if (dq.size() > 0 && dq[0].due <= cyc) begin
                    chk("d_missing_rvalid", 32'd0, 32'd1);
                    void'(dq.pop_front());
                end
            end
        end
    end

    function automatic vec_t mk(input string tag, input logic fr, input logic [31:0] fa,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic efg, input logic edg,
                                input logic [31:0] erd);
        vec_t v;
        v.tag = tag; v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.efg = efg; v.edg = edg; v.erd = erd;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    endtask

    // Both ports contending: fetch 0x20 (word 8), debug read 0x24 (word 9).
    task automatic both(input string tag, input logic efg);
        apply(mk(tag, 1, 32'h20, 1, 0, 32'h24, 0, efg, ~efg,
                 efg ? 32'h1000_0008 : 32'h1000_0009), 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_f_gnt"}, 32'(f_gnt_o), 0);
        chk({tag, "_d_gnt"}, 32'(d_gnt_o), 0);
        chk({tag, "_mem_ce"}, 32'(mem_ce_o), 0);
        chk({tag, "_mem_we"}, 32'(mem_we_o), 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_stall"}, 32'(fetch_stall_o), 0);
        chk({tag, "_f_rvalid"}, 32'(f_rvalid_o), 0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid_o), 0);
        chk({tag, "_f_rdata"}, f_rdata_o, 0);
        chk({tag, "_d_rdata"}, d_rdata_o, 0);
    endtask

    initial begin
        // Reset state, with requests asserted to prove combinational outputs are forced low.
        f_req_i = 1'b1; d_req_i = 1'b1; f_addr_i = 32'h4; d_addr_i = 32'h8;
        repeat (2) @(posedge clk);
        #2;
        chk_all_zero("reset");
        f_req_i = 1'b0; d_req_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // 1: fetch only, consecutive addresses.
        apply(mk("t1_f0", 1, 32'h0, 0, 0, 0, 0, 1, 0, 32'h1000_0000), 1'b1);
        apply(mk("t1_f4", 1, 32'h4, 0, 0, 0, 0, 1, 0, 32'h1000_0001), 1'b1);
        apply(mk("t1_f8", 1, 32'h8, 0, 0, 0, 0, 1, 0, 32'h1000_0002), 1'b1);
        idle(1);

        // 2: debug write then read back.
        apply(mk("t2_dw", 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 1, 0), 1'b1);
        apply(mk("t2_dr", 0, 0, 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF), 1'b1);
        idle(1);

        // 3: continuous contention -> D,D,D,D,F repeating.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) both("t3_D", 1'b0);
            both("t3_F", 1'b1);
        end
        idle(1);

        // 4: fetch drops mid-burst; counter clears, next four contended cycles go to debug.
        both("t4_D", 1'b0);
        both("t4_D", 1'b0);
        apply(mk("t4_donly", 0, 0, 1, 0, 32'h24, 0, 0, 1, 32'h1000_0009), 1'b1);
        for (int k = 0; k < 4; k++) both("t4_D", 1'b0);
        both("t4_F", 1'b1);
        idle(1);

        // 5: reset asserted the cycle after a fetch grant drops the pending response.
        apply(mk("t5_f", 1, 32'h8, 0, 0, 0, 0, 1, 0, 32'h1000_0002), 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_all_zero("t5_in_reset");
        @(posedge clk);
        #2 chk_all_zero("t5_in_reset2");
        f_req_i = 1'b0;
        #1 rst = 1'b1;
        #1 chk("t5_after_release_f_rvalid", 32'(f_rvalid_o), 0);
        apply(mk("t5_post", 1, 32'h4, 0, 0, 0, 0, 1, 0, 32'h1000_0001), 1'b1);

        // 6: alternating fetch/debug reads back to back.
        apply(mk("t6_f", 1, 32'h0C, 0, 0, 0, 0, 1, 0, 32'h1000_0003), 1'b1);
        apply(mk("t6_d", 0, 0, 1, 0, 32'h14, 0, 0, 1, 32'h1000_0005), 1'b1);
        apply(mk("t6_f", 1, 32'h18, 0, 0, 0, 0, 1, 0, 32'h1000_0006), 1'b1);
        apply(mk("t6_d", 0, 0, 1, 0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF), 1'b1);
        idle(3);

        chk("f_queue_drained", 32'(fq.size()), 0);
        chk("d_queue_drained", 32'(dq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
